// File: rtl/com_uart_pkg.sv
// Shared definitions for the COM UART: TX/RX state encodings and bit-timing helpers.
package com_uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Clocks per serial bit, integer floor.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int uart_half(input int clk_freq, input int baud);
        return uart_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/com_uart_rx.sv
// UART receiver: rxd synchronizer, mid-bit sampling FSM and received-byte holding register.
module com_uart_rx
    import com_uart_pkg::*;
#(
    parameter int DIV  = 434,
    parameter int HALF = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       int_com_ack,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    output logic       rx_error,
    output logic [1:0] rx_state_dbg
);

    localparam int CW = $clog2(DIV + 1);

    rx_state_t     rx_state, rx_next;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sample_bit;
    logic          load;
    logic          frame_err;

    assign rx_s         = sync_q[1];
    assign rx_state_dbg = rx_state;

    always_comb begin
        rx_next    = rx_state;
        sample_bit = 1'b0;
        load       = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            // Resample at mid-start; a line already back high was only a glitch.
            RX_START: if (cnt == CW'(HALF - 1)) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (cnt == CW'(DIV - 1)) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(DIV - 1)) begin
                    rx_next   = RX_IDLE;
                    load      = rx_s;
                    frame_err = !rx_s;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q         <= 2'b11;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            com_data_in    <= '0;
            com_read_ready <= 1'b0;
            rx_error       <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd};

            if (rx_state == RX_IDLE || rx_next != rx_state || sample_bit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (rx_state != RX_DATA) begin
                bit_idx <= '0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (sample_bit) shreg <= {rx_s, shreg[7:1]};

            // A new byte takes priority over an acknowledge in the same cycle.
            if (load) begin
                com_data_in    <= shreg;
                com_read_ready <= 1'b1;
                if (com_read_ready) rx_error <= 1'b1;
            end else if (int_com_ack) begin
                com_read_ready <= 1'b0;
            end

            if (frame_err) rx_error <= 1'b1;
        end
    end

endmodule

// File: rtl/com_uart.sv
// COM UART top: 8N1 transmitter FSM plus an independent receiver sub-module.
module com_uart
    import com_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] com_data_out,
    input  logic       enable_com_write,
    output logic       com_write_ready,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    input  logic       int_com_ack,
    output logic       rx_error,
    output logic       txd,
    input  logic       rxd,
    output logic [1:0] tx_state_dbg,
    output logic [1:0] rx_state_dbg
);

    localparam int DIV  = uart_div(CLK_FREQ, BAUD);
    localparam int HALF = uart_half(CLK_FREQ, BAUD);
    localparam int CW   = $clog2(DIV + 1);

    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit_idx;
    logic [7:0]    tx_shreg;
    logic          accept;
    logic          bit_end;

    assign com_write_ready = (tx_state == TX_IDLE);
    assign tx_state_dbg    = tx_state;
    assign bit_end         = (tx_cnt == CW'(DIV - 1));

    always_comb begin
        tx_next = tx_state;
        accept  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (enable_com_write) begin
                    accept  = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: if (bit_end) tx_next = TX_DATA;
            TX_DATA:  if (bit_end && tx_bit_idx == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // txd is registered so the start bit appears on the cycle right after acceptance.
    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            txd        <= 1'b1;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shreg   <= '0;
        end else begin
            if (tx_state == TX_IDLE || bit_end) begin
                tx_cnt <= '0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end

            if (accept) begin
                tx_shreg   <= com_data_out;
                tx_bit_idx <= '0;
                txd        <= 1'b0;
            end else if (bit_end) begin
                case (tx_state)
                    TX_START: begin
                        txd      <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                    end
                    TX_DATA: begin
                        tx_bit_idx <= tx_bit_idx + 1'b1;
                        if (tx_bit_idx == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            txd      <= tx_shreg[0];
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                        end
                    end
                    default: txd <= 1'b1;
                endcase
            end
        end
    end

    com_uart_rx #(
        .DIV  (DIV),
        .HALF (HALF)
    ) u_rx (
        .clk            (clk50M),
        .rst_n          (rst_n),
        .rxd            (rxd),
        .int_com_ack    (int_com_ack),
        .com_data_in    (com_data_in),
        .com_read_ready (com_read_ready),
        .rx_error       (rx_error),
        .rx_state_dbg   (rx_state_dbg)
    );

endmodule

// File: tb/tb_com_uart.sv
// Directed bench for com_uart at CLK_FREQ=160, BAUD=10 (16 clocks per bit).
module tb_com_uart;

    localparam int DIV = 16;

    logic       clk50M = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] com_data_out = 8'h00;
    logic       enable_com_write = 1'b0;
    logic       com_write_ready;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       int_com_ack = 1'b0;
    logic       rx_error;
    logic       txd;
    logic       rxd = 1'b1;
    logic [1:0] tx_state_dbg;
    logic [1:0] rx_state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    com_uart #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk50M           (clk50M),
        .rst_n            (rst_n),
        .com_data_out     (com_data_out),
        .enable_com_write (enable_com_write),
        .com_write_ready  (com_write_ready),
        .com_data_in      (com_data_in),
        .com_read_ready   (com_read_ready),
        .int_com_ack      (int_com_ack),
        .rx_error         (rx_error),
        .txd              (txd),
        .rxd              (rxd),
        .tx_state_dbg     (tx_state_dbg),
        .rx_state_dbg     (rx_state_dbg)
    );

    always #5 clk50M = ~clk50M;

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level of frame bit idx (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic tx_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Accepts one byte and checks every bit boundary; optionally pulses a 0x3C request mid-frame.
    task automatic tx_frame(input logic [7:0] b, input int inject_at);
        int bi;
        int c;
        com_data_out     = b;
        enable_com_write = 1'b1;
        tick();
        enable_com_write = 1'b0;
        com_data_out     = 8'h00;
        check_eq("tx_ready_low", {15'd0, com_write_ready}, 16'd0);
        for (int n = 0; n < 10 * DIV; n++) begin
            bi = n / DIV;
            c  = n % DIV;
            if (c == 0 || c == DIV - 1)
                check_eq($sformatf("txd_bit%0d_c%0d", bi, c), {15'd0, txd}, {15'd0, tx_bit(b, bi)});
            if (n == 10 * DIV - 1)
                check_eq("tx_ready_last", {15'd0, com_write_ready}, 16'd0);
            if (n == inject_at) begin
                com_data_out     = 8'h3C;
                enable_com_write = 1'b1;
            end
            tick();
            enable_com_write = 1'b0;
            com_data_out     = 8'h00;
        end
        check_eq("tx_ready_done", {15'd0, com_write_ready}, 16'd1);
        check_eq("tx_idle_txd", {15'd0, txd}, 16'd1);
        check_eq("tx_state_idle", {14'd0, tx_state_dbg}, 16'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 9) ? stop_bit : tx_bit(b, i);
            repeat (DIV) tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check_eq("rst_txd", {15'd0, txd}, 16'd1);
        check_eq("rst_wready", {15'd0, com_write_ready}, 16'd1);
        check_eq("rst_rready", {15'd0, com_read_ready}, 16'd0);
        check_eq("rst_data_in", {8'd0, com_data_in}, 16'h0000);
        check_eq("rst_rx_error", {15'd0, rx_error}, 16'd0);
        check_eq("rst_tx_state", {14'd0, tx_state_dbg}, 16'd0);
        check_eq("rst_rx_state", {14'd0, rx_state_dbg}, 16'd0);
        rst_n = 1'b1;
        tick();

        // 0xA5 with an ignored 0x3C request at cycle 50.
        tx_frame(8'hA5, 50);

        exp_q.push_back(8'h5A);
        rx_frame(8'h5A, 1'b1);
        rxd = 1'b1;
        repeat (3) tick();
        check_eq("rx_rready", {15'd0, com_read_ready}, 16'd1);
        check_eq("rx_data", {8'd0, com_data_in}, {8'd0, exp_q.pop_front()});
        check_eq("rx_no_error", {15'd0, rx_error}, 16'd0);
        int_com_ack = 1'b1;
        tick();
        int_com_ack = 1'b0;
        check_eq("rx_ack_clears", {15'd0, com_read_ready}, 16'd0);
        check_eq("rx_data_stable", {8'd0, com_data_in}, 16'h005A);

        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (20) tick();
        check_eq("glitch_state", {14'd0, rx_state_dbg}, 16'd0);
        check_eq("glitch_rready", {15'd0, com_read_ready}, 16'd0);
        check_eq("glitch_error", {15'd0, rx_error}, 16'd0);
        check_eq("glitch_data", {8'd0, com_data_in}, 16'h005A);

        rx_frame(8'h77, 1'b0);
        rxd = 1'b1;
        repeat (3 * DIV) tick();
        check_eq("frame_err", {15'd0, rx_error}, 16'd1);
        check_eq("frame_rready", {15'd0, com_read_ready}, 16'd0);
        check_eq("frame_data", {8'd0, com_data_in}, 16'h005A);
        check_eq("frame_rx_idle", {14'd0, rx_state_dbg}, 16'd0);

        // Back-to-back frames without ack: overrun must raise rx_error from a clean reset.
        do_reset();
        check_eq("reset_clears_error", {15'd0, rx_error}, 16'd0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        rx_frame(8'h11, 1'b1);
        check_eq("b2b_first_data", {8'd0, com_data_in}, {8'd0, exp_q.pop_front()});
        check_eq("b2b_first_rready", {15'd0, com_read_ready}, 16'd1);
        check_eq("b2b_first_error", {15'd0, rx_error}, 16'd0);
        rx_frame(8'h22, 1'b1);
        rxd = 1'b1;
        repeat (3) tick();
        check_eq("overrun_data", {8'd0, com_data_in}, {8'd0, exp_q.pop_front()});
        check_eq("overrun_rready", {15'd0, com_read_ready}, 16'd1);
        check_eq("overrun_error", {15'd0, rx_error}, 16'd1);
        int_com_ack = 1'b1;
        tick();
        int_com_ack = 1'b0;
        check_eq("error_sticky", {15'd0, rx_error}, 16'd1);

        // Reset in the middle of data bit 4 of a frame.
        com_data_out     = 8'hA5;
        enable_com_write = 1'b1;
        tick();
        enable_com_write = 1'b0;
        repeat (5 * DIV + 8) tick();
        check_eq("mid_tx_txd", {15'd0, txd}, {15'd0, tx_bit(8'hA5, 5)});
        check_eq("mid_tx_busy", {15'd0, com_write_ready}, 16'd0);
        rst_n = 1'b0;
        tick();
        check_eq("abort_txd", {15'd0, txd}, 16'd1);
        check_eq("abort_wready", {15'd0, com_write_ready}, 16'd1);
        check_eq("abort_tx_state", {14'd0, tx_state_dbg}, 16'd0);
        rst_n = 1'b1;
        tick();
        tx_frame(8'h3C, -1);

        check_eq("exp_q_empty", exp_q.size()[15:0], 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
